// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline stage enable / flush controller with a memory-wait FSM.
//
// Decides every cycle, combinationally from the registered FSM state and the
// hazard/memory inputs, which pipeline registers capture and which are cleared.
// A data-memory access that is not ready freezes the whole pipe (MEMWAIT).
// A wait that lasts longer than TIMEOUT cycles parks the FSM in HALT with a
// sticky error flag until reset.
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the saturating
// performance counters. Without it the counter outputs are tied to zero and
// no counter flops exist.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   stallFD, flushED               load-use stall / control-transfer squash
//   memreqM, memreadyM             M-stage access present / access completes
//   enF, enD, enE, enM             capture enables (PC, IF/ID, ID/EX, EX/MEM)
//   flushD, flushE, flushW         bubble insert into IF/ID, ID/EX, MEM/WB
//   memerr                         sticky memory-timeout flag
//   stallcnt, flushcnt, waitcnt    performance counters (CNT_W bits each)
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallFD,
  input  logic             flushED,
  input  logic             memreqM,
  input  logic             memreadyM,
  output logic             enF,
  output logic             enD,
  output logic             enE,
  output logic             enM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic             memerr,
  output logic [CNT_W-1:0] stallcnt,
  output logic [CNT_W-1:0] flushcnt,
  output logic [CNT_W-1:0] waitcnt
);

  typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, HALT = 2'd2} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       memerr_q, memerr_d;
  logic       mem_stall;
  logic       freeze;

  assign mem_stall = memreqM & ~memreadyM;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      wcnt_q   <= 8'd0;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      memerr_q <= memerr_d;
    end
  end

  // Next-state logic. The wait counter counts frozen cycles of the current
  // access, starting at 1 on the RUN cycle that detects the stall; it is
  // compared to TIMEOUT before incrementing, so it never exceeds 255.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    memerr_d = memerr_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEMWAIT;
          wcnt_d  = 8'd1;
        end
      end
      MEMWAIT: begin
        if (memreadyM) begin
          state_d = RUN;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == TIMEOUT_C) begin
          state_d  = HALT;
          memerr_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      HALT: begin
        memerr_d = 1'b1;
      end
      default: begin
        state_d = RUN;
        wcnt_d  = 8'd0;
      end
    endcase
  end

  // Output logic. A frozen pipe ignores stallFD/flushED entirely: the held
  // E stage re-presents the same requests once the access completes.
  always_comb begin
    case (state_q)
      RUN:     freeze = mem_stall;
      MEMWAIT: freeze = ~memreadyM;
      default: freeze = 1'b1;
    endcase

    enF    = 1'b1;
    enD    = 1'b1;
    enE    = 1'b1;
    enM    = 1'b1;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;

    if (freeze) begin
      enF    = 1'b0;
      enD    = 1'b0;
      enE    = 1'b0;
      enM    = 1'b0;
      flushW = 1'b1;
    end else if (flushED) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (stallFD) begin
      enF    = 1'b0;
      enD    = 1'b0;
      flushE = 1'b1;
    end
  end

  assign memerr = memerr_q;

`ifdef PIPE_CTRL_PERF_EN
  // Counter 0: load-use stall cycles (front frozen while E still advances),
  // counter 1: squash cycles, counter 2: cycles with EX/MEM frozen.
  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  assign cnt_inc[0] = ~enF & enE;
  assign cnt_inc[1] = flushD;
  assign cnt_inc[2] = ~enM;

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    always_comb begin
      cnt_d[gi] = cnt_q[gi];
      if (cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}}))
        cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q[gi] <= '0;
      else        cnt_q[gi] <= cnt_d[gi];
    end
  end

  assign stallcnt = cnt_q[0];
  assign flushcnt = cnt_q[1];
  assign waitcnt  = cnt_q[2];
`else
  assign stallcnt = '0;
  assign flushcnt = '0;
  assign waitcnt  = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum MEMWAIT cycles tolerated before halting; legal range 1..255.
REQ-002 Parameter CNT_W, default 32: width of each performance counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 stallFD  input  1  load-use stall request from the hazard unit.
REQ-006 flushED  input  1  control-transfer squash request from the hazard unit.
REQ-007 memreqM  input  1  load or store occupies the Memory stage this cycle.
REQ-008 memreadyM  input  1  data memory completes the M-stage access this cycle.
REQ-009 enF, enD, enE, enM  output  1 each  capture enable for the PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-010 flushD, flushE, flushW  output  1 each  synchronous clear (bubble insert) of IF/ID, ID/EX and MEM/WB.
REQ-011 memerr  output  1  sticky memory-timeout error flag.
REQ-012 stallcnt, flushcnt, waitcnt  output  CNT_W each  performance counters.

Function
REQ-013 FSM states: RUN, MEMWAIT, HALT; held in a registered state variable.
REQ-014 Stage outputs are combinational from state and inputs, giving zero-cycle decision latency.
REQ-015 Memory stall condition in RUN: memreqM=1 and memreadyM=0.
REQ-016 RUN, no requests pending: all en*=1, all flush*=0.
REQ-017 RUN with flushED=1 and no memory stall: enF=enD=enE=enM=1, flushD=1, flushE=1, flushW=0.
REQ-018 RUN with stallFD=1, flushED=0 and no memory stall: enF=enD=0, enE=enM=1, flushE=1, flushD=flushW=0.
REQ-019 When stallFD and flushED are both 1, flushED has priority and REQ-017 applies.
REQ-020 RUN with a memory stall: enF=enD=enE=enM=0, flushW=1, flushD=flushE=0, next state MEMWAIT, and the wait counter loads 1.
REQ-021 A memory stall overrides stallFD and flushED; neither is latched, because a frozen E stage re-presents the same requests when the pipeline resumes.
REQ-022 MEMWAIT with memreadyM=0: outputs as in REQ-020, and the wait counter increments.
REQ-023 MEMWAIT with memreadyM=1: outputs are decoded exactly as in RUN (REQ-016..019) and the next state is RUN.
REQ-024 MEMWAIT when the wait counter equals TIMEOUT and memreadyM=0: next state HALT and memerr is set.
REQ-025 HALT: all en*=0, flushW=1, flushD=flushE=0; the FSM stays in HALT until reset and memerr stays 1.
REQ-026 memreqM=1 with memreadyM=1 in RUN causes no stall.
REQ-027 The wait counter is 8 bits wide and never wraps, because TIMEOUT<=255.

Reset
REQ-028 rst_n low asynchronously forces state=RUN, wait counter=0, memerr=0 and all performance counters=0.
REQ-029 With inputs idle, outputs after reset are en*=1, flush*=0, memerr=0 and counters=0.
REQ-030 Reset asserted in MEMWAIT or HALT returns the FSM to RUN; no pending access is remembered.

Configuration
REQ-031 Macro PIPE_CTRL_PERF_EN defined: stallcnt increments on every cycle REQ-018 applies.
REQ-032 Macro PIPE_CTRL_PERF_EN defined: flushcnt increments on every cycle REQ-017 applies.
REQ-033 Macro PIPE_CTRL_PERF_EN defined: waitcnt increments on every cycle enM=0.
REQ-034 Macro PIPE_CTRL_PERF_EN defined: every performance counter saturates at all-ones.
REQ-035 Macro PIPE_CTRL_PERF_EN undefined: stallcnt, flushcnt and waitcnt are constant 0 and no counter flops are generated.

Verification
REQ-036 Bench: stallFD=1 for 1 cycle in RUN -> enF=enD=0, flushE=1 that cycle; stallcnt +1 with PERF on.
REQ-037 Bench: stallFD=1 and flushED=1 together -> flushD=flushE=1, enF=1; flushcnt +1, stallcnt unchanged.
REQ-038 Bench: memreqM=1, memreadyM=0 for 3 cycles, then memreadyM=1 -> enM=0 for 3 cycles, all en*=1 on the 4th cycle, state RUN; waitcnt=3.
REQ-039 Bench: flushED=1 held through a 2-cycle memory wait -> flushD=flushE=0 during the wait; flushD=flushE=1 on the memreadyM cycle.
REQ-040 Bench: TIMEOUT=4 with memreadyM held 0 -> HALT entered after 4 MEMWAIT cycles, memerr=1 sticky, all en*=0; rst_n pulse -> RUN, memerr=0.
REQ-041 Bench: rst_n asserted mid-MEMWAIT -> state RUN, counters 0 immediately, without waiting for a clock edge.
